// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b, cin on start, then adds one bit per clock LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_cn;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Operands shift right so the bit being added is always at position 0.
  assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cn       = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  assign w_last     = (r_idx == IW'(WIDTH - 1));
  assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_idx   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_acc <= w_acc_next;
          r_idx <= r_idx + 1'b1;
          // Results only become visible on the final bit so sum never shows partial values.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_cn;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= r_c ^ w_cn;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = r_ovf;
`endif
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main cases and a 1-bit instance
// for the degenerate width; expected results are hand-computed constants.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;
  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] st1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(st8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .dbg_state(st1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: call just after a negedge; the following posedge is the accepting edge E0.
  task automatic run_add(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic ec,
                         input logic eo, input bit disturb);
    int lat, busy_n;
    logic held_bad;
    logic [7:0] pre_sum;
    logic [8:0] exp;
    exp_q.push_back({ec, es});
    pre_sum = sum8;
    start8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    if (disturb) begin
      a8 = ~va; b8 = ~vb; cin8 = ~vc;
    end
    busy_n = 0;
    held_bad = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (disturb && lat == 3) begin
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3;
      end
      if (disturb && lat == 4) start8 = 1'b0;
      if (done8) break;
      if (busy8) busy_n++;
      if (sum8 !== pre_sum) held_bad = 1'b1;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_n, 8);
    check({tag, "_sum_hold"}, {31'd0, held_bad}, 0);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp[7:0]});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp[8]});
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation for %s", tag);
`endif
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done8}, 0);
    check({tag, "_back_idle"}, {30'd0, st8}, 0);
  endtask

  task automatic run_add1(input string tag, input logic va, input logic vb, input logic vc,
                          input logic es, input logic ec);
    int lat;
    start1 = 1'b1; a1 = va; b1 = vb; cin1 = vc;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (done1) break;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_sum"}, {31'd0, sum1}, {31'd0, es});
    check({tag, "_cout"}, {31'd0, cout1}, {31'd0, ec});
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done1}, 0);
  endtask

  initial begin
    int lat_a, period;
    logic done_seen;
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_cout", {31'd0, cout8}, 0);
    check("rst_state", {30'd0, st8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Accepted on the first edge after reset release
    run_add("add_25_17", 8'h25, 8'h17, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_add("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_add("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_add("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    run_add("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_add("add_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_add("add_disturb", 8'h3A, 8'h47, 1'b1, 8'h82, 1'b0, 1'b1, 1'b1);

    // start held high: back-to-back operations every WIDTH+2 cycles
    start8 = 1'b1; a8 = 8'h25; b8 = 8'h17; cin8 = 1'b0;
    @(posedge clk);
    for (lat_a = 1; lat_a <= 40; lat_a++) begin
      @(negedge clk);
      if (done8) break;
    end
    check("held_first_latency", lat_a, 9);
    for (period = 1; period <= 40; period++) begin
      @(negedge clk);
      if (done8) break;
    end
    start8 = 1'b0;
    check("held_period", period, 10);
    check("held_sum", {24'd0, sum8}, 32'h3C);
    repeat (2) @(negedge clk);
    check("held_idle", {30'd0, st8}, 0);

    // Reset in the middle of RUN aborts with no done and clears the held result
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_done", {31'd0, done8}, 0);
    check("abort_sum", {24'd0, sum8}, 0);
    check("abort_cout", {31'd0, cout8}, 0);
    check("abort_state", {30'd0, st8}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", {31'd0, ovf8}, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) done_seen = 1'b1;
    end
    check("abort_no_done", {31'd0, done_seen}, 0);
    check("abort_sum_kept", {24'd0, sum8}, 0);

    rst = 1'b1;
    #1 rst = 1'b0;
    run_add("post_rst", 8'h25, 8'h17, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    run_add1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_add1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_add1("w1_110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
